ofdm_eq_symbol_scheduler: RTL and testbench

OFDM_EQ_SYMBOL_SCHEDULER -- requirements
Module: ofdm_eq_symbol_scheduler

---
 rtl/ofdm_eq_symbol_scheduler.sv | 166 ++++++++++++++++
 tb/tb_ofdm_eq_symbol_scheduler.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofdm_eq_symbol_scheduler.sv
// OFDM symbol scheduler: strips the cyclic prefix from a framed sample stream and
// forwards body subcarriers toward the equalizer with SOP/EOP, pilot and symbol tags.
module ofdm_eq_symbol_scheduler #(
    parameter int N_FFT         = 64,
    parameter int N_CP          = 16,
    parameter int PILOT_SPACING = 8,
    parameter int SYM_PER_FRAME = 14
) (
    input  logic        clock_clk,
    input  logic        reset_reset_n,
    input  logic [33:0] asi_in0_data,
    input  logic        asi_in0_valid,
    input  logic        asi_in0_startofpacket,
    output logic        asi_in0_ready,
    output logic [33:0] aso_out0_data,
    output logic        aso_out0_valid,
    input  logic        aso_out0_ready,
    output logic        aso_out0_startofpacket,
    output logic        aso_out0_endofpacket,
    output logic        coe_pilot,
    output logic [15:0] coe_sym_idx,
    output logic        coe_frame_done,
    output logic        coe_sop_err
);
    localparam int BMAX = (N_FFT > N_CP) ? N_FFT : N_CP;
    localparam int BW   = $clog2(BMAX);
    localparam int SW   = (SYM_PER_FRAME > 1) ? $clog2(SYM_PER_FRAME) : 1;

    localparam logic [BW-1:0] FFT_LAST = BW'(N_FFT - 1);
    localparam logic [BW-1:0] CP_LAST  = BW'(N_CP - 1);
    localparam logic [BW-1:0] PMASK    = BW'(PILOT_SPACING - 1);
    localparam logic [SW-1:0] SYM_LAST = SW'(SYM_PER_FRAME - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CP   = 2'd1;
    localparam logic [1:0] S_BODY = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [SW-1:0] sym_q, sym_d;
    logic          out_valid_q, out_valid_d;
    logic [33:0]   out_data_q, out_data_d;
    logic          out_sop_q, out_sop_d;
    logic          out_eop_q, out_eop_d;
    logic          out_pilot_q, out_pilot_d;
    logic [SW-1:0] out_sym_q, out_sym_d;
    logic          err_q, err_d;
    logic          in_ready;
    logic          accept;
    logic          frame_done;
    logic          sop_expected;

    always_comb begin
        in_ready = 1'b0;
        if (reset_reset_n) begin
            case (state_q)
                S_IDLE, S_CP: in_ready = 1'b1;
                S_BODY:       in_ready = !out_valid_q || aso_out0_ready;
                default:      in_ready = 1'b0;
            endcase
        end
    end

    assign accept = asi_in0_valid && in_ready;
    // SOP is only legitimate in IDLE or on the first CP beat after a completed symbol.
    assign sop_expected = (state_q == S_IDLE) || ((state_q == S_CP) && (beat_q == '0));

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        sym_d       = sym_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        out_pilot_d = out_pilot_q;
        out_sym_d   = out_sym_q;
        err_d       = err_q;
        frame_done  = 1'b0;

        if (aso_out0_ready) out_valid_d = 1'b0;

        if (accept) begin
            if (asi_in0_startofpacket) begin
                if (!sop_expected) err_d = 1'b1;
                sym_d = '0;
                if (N_CP == 1) begin
                    state_d = S_BODY;
                    beat_d  = '0;
                end else begin
                    state_d = S_CP;
                    beat_d  = BW'(1);
                end
            end else begin
                case (state_q)
                    S_CP: begin
                        if (beat_q == CP_LAST) begin
                            state_d = S_BODY;
                            beat_d  = '0;
                        end else begin
                            beat_d = beat_q + BW'(1);
                        end
                    end
                    S_BODY: begin
                        out_valid_d = 1'b1;
                        out_data_d  = asi_in0_data;
                        out_sop_d   = (beat_q == '0);
                        out_eop_d   = (beat_q == FFT_LAST);
                        out_pilot_d = ((beat_q & PMASK) == '0);
                        out_sym_d   = sym_q;
                        if (beat_q == FFT_LAST) begin
                            beat_d = '0;
                            if (sym_q == SYM_LAST) begin
                                state_d    = S_IDLE;
                                sym_d      = '0;
                                frame_done = 1'b1;
                            end else begin
                                state_d = S_CP;
                                sym_d   = sym_q + SW'(1);
                            end
                        end else begin
                            beat_d = beat_q + BW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clock_clk) begin
        if (!reset_reset_n) begin
            state_q     <= S_IDLE;
            beat_q      <= '0;
            sym_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_pilot_q <= 1'b0;
            out_sym_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            sym_q       <= sym_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            out_pilot_q <= out_pilot_d;
            out_sym_q   <= out_sym_d;
            err_q       <= err_d;
        end
    end

    assign asi_in0_ready          = in_ready;
    assign aso_out0_data          = out_data_q;
    assign aso_out0_valid         = out_valid_q;
    assign aso_out0_startofpacket = out_sop_q;
    assign aso_out0_endofpacket   = out_eop_q;
    assign coe_pilot              = out_pilot_q;
    assign coe_sym_idx            = 16'(out_sym_q);
    assign coe_frame_done         = frame_done;
    assign coe_sop_err            = err_q;
endmodule

// File: tb/tb_ofdm_eq_symbol_scheduler.sv
// Bench for the OFDM symbol scheduler: a cycle table for the basic frame, hand-written
// stall/restart/reset sequences, and a randomized stream against a frame-position model.
module tb_ofdm_eq_symbol_scheduler;
    localparam int N_FFT = 8;
    localparam int N_CP  = 2;
    localparam int PS    = 4;
    localparam int SPF   = 2;
    localparam int L     = N_CP + N_FFT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [33:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_sop = 1'b0;
    logic        in_ready;
    logic [33:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_sop, out_eop, pilot, frame_done, sop_err;
    logic [15:0] sym_idx;

    ofdm_eq_symbol_scheduler #(
        .N_FFT(N_FFT), .N_CP(N_CP), .PILOT_SPACING(PS), .SYM_PER_FRAME(SPF)
    ) dut (
        .clock_clk(clk), .reset_reset_n(rst_n),
        .asi_in0_data(in_data), .asi_in0_valid(in_valid),
        .asi_in0_startofpacket(in_sop), .asi_in0_ready(in_ready),
        .aso_out0_data(out_data), .aso_out0_valid(out_valid), .aso_out0_ready(out_ready),
        .aso_out0_startofpacket(out_sop), .aso_out0_endofpacket(out_eop),
        .coe_pilot(pilot), .coe_sym_idx(sym_idx),
        .coe_frame_done(frame_done), .coe_sop_err(sop_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [33:0] d;
        logic        sop;
    } ibeat_t;

    typedef struct packed {
        logic [33:0] d;
        logic        sop;
        logic        eop;
        logic        pil;
        logic [15:0] sym;
    } obeat_t;

    typedef struct {
        logic        vld;
        logic [33:0] d;
        logic        sop;
        logic        eop;
        logic        pil;
        logic [15:0] sym;
        logic        fd;
    } vec_t;

    int     compared = 0;
    int     mismatched = 0;
    int     fd_cnt = 0;
    int     exp_fd;
    bit     exp_err;
    bit     drv_done;
    ibeat_t in_q[$];
    ibeat_t sent_q[$];
    obeat_t out_q[$];
    obeat_t exp_q[$];
    vec_t   tbl[21];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid && out_ready)
            out_q.push_back('{d: out_data, sop: out_sop, eop: out_eop, pil: pilot, sym: sym_idx});
        if (frame_done) fd_cnt++;
    end

    // Reference: position within a frame decides CP vs body, independent of any FSM.
    task automatic model();
        bit in_frame = 0;
        int p = 0;
        exp_q.delete();
        exp_fd  = 0;
        exp_err = 0;
        foreach (sent_q[i]) begin
            if (sent_q[i].sop) begin
                if (in_frame && (p % L) != 0) exp_err = 1;
                in_frame = 1;
                p = 0;
            end
            if (in_frame) begin
                int off = p % L;
                if (off >= N_CP) begin
                    int idx = off - N_CP;
                    exp_q.push_back('{d: sent_q[i].d, sop: idx == 0, eop: idx == N_FFT - 1,
                                      pil: (idx % PS) == 0, sym: 16'(p / L)});
                end
                p++;
                if (p == SPF * L) begin
                    in_frame = 0;
                    exp_fd++;
                end
            end
        end
    endtask

    task automatic push_beat(input logic [33:0] d, input logic s);
        in_q.push_back('{d: d, sop: s});
        sent_q.push_back('{d: d, sop: s});
    endtask

    task automatic push_frame(input int base);
        for (int i = 0; i < SPF * L; i++) push_beat(34'(base + i), i == 0);
    endtask

    // Called just after a rising edge; each beat is held until the bench sees it accepted.
    task automatic drive(input int gap_pct);
        ibeat_t b;
        while (in_q.size() > 0) begin
            bit acc;
            int to;
            b = in_q.pop_front();
            while (int'($urandom_range(99)) < gap_pct) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = b.d;
            in_sop   = b.sop;
            to = 0;
            do begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk); #1;
                to++;
            end while (!acc && to < 1000);
            if (!acc) chk("accept_timeout", 64'(acc), 64'd1);
        end
        in_valid = 1'b0;
        in_sop   = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic start_stream();
        in_q.delete();
        sent_q.delete();
        out_q.delete();
        fd_cnt = 0;
    endtask

    task automatic compare_stream(input string tag, input bit chk_err);
        model();
        chk($sformatf("%s_len", tag), 64'(out_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_beat%0d", tag, i), 64'(out_q[i]), 64'(exp_q[i]));
        chk($sformatf("%s_frame_done", tag), 64'(fd_cnt), 64'(exp_fd));
        if (chk_err) chk($sformatf("%s_sop_err", tag), 64'(sop_err), 64'(exp_err));
    endtask

    task automatic run_table(input int pre);
        for (int i = 0; i < pre; i++) begin
            in_valid = 1'b1; in_data = 34'(100 + i); in_sop = 1'b0;
            @(negedge clk);
            chk($sformatf("pre%0d_valid", i), 64'(out_valid), 64'd0);
            chk($sformatf("pre%0d_ready", i), 64'(in_ready), 64'd1);
            @(posedge clk); #1;
        end
        for (int k = 0; k < 21; k++) begin
            in_valid = (k < 20);
            in_data  = 34'(k);
            in_sop   = (k == 0);
            @(negedge clk);
            chk($sformatf("t%0d_c%0d_valid", pre, k), 64'(out_valid), 64'(tbl[k].vld));
            if (tbl[k].vld) begin
                chk($sformatf("t%0d_c%0d_data", pre, k), 64'(out_data), 64'(tbl[k].d));
                chk($sformatf("t%0d_c%0d_tags", pre, k), {out_sop, out_eop, pilot, sym_idx},
                    {tbl[k].sop, tbl[k].eop, tbl[k].pil, tbl[k].sym});
            end
            chk($sformatf("t%0d_c%0d_fd", pre, k), 64'(frame_done), 64'(tbl[k].fd));
            chk($sformatf("t%0d_c%0d_err", pre, k), 64'(sop_err), 64'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_sop   = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Beat k of a frame starting at beat 0 appears on the output one cycle later.
        for (int k = 0; k < 21; k++) begin
            int b;
            b = k - 1;
            tbl[k].vld = ((b >= 2) && (b <= 9)) || ((b >= 12) && (b <= 19));
            tbl[k].d   = 34'(b);
            tbl[k].sop = (b == 2) || (b == 12);
            tbl[k].eop = (b == 9) || (b == 19);
            tbl[k].pil = (b == 2) || (b == 6) || (b == 12) || (b == 16);
            tbl[k].sym = (b >= 12) ? 16'd1 : 16'd0;
            tbl[k].fd  = (k == 19);
        end

        // Reset state, with a SOP beat offered to show ready is held low.
        in_valid = 1'b1; in_sop = 1'b1; in_data = 34'h3_1234_5678;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(in_ready), 64'd0);
        chk("rst_outs", {out_valid, out_sop, out_eop, pilot, frame_done, sop_err}, 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_sym", 64'(sym_idx), 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0; in_sop = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_table(0);
        run_table(5);

        // Backpressure at body index 3 (beat 5) for 3 cycles.
        start_stream();
        push_frame(0);
        drv_done = 0;
        fork
            begin drive(0); drv_done = 1; end
            begin
                int to = 0;
                bit hit = 0;
                while (!hit && to < 100) begin
                    @(posedge clk); #1;
                    hit = out_valid && (out_data == 34'd5);
                    to++;
                end
                chk("stall_found", 64'(hit), 64'd1);
                out_ready = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk($sformatf("stall%0d_data", i), 64'(out_data), 64'd5);
                    chk($sformatf("stall%0d_valid", i), 64'(out_valid), 64'd1);
                    chk($sformatf("stall%0d_inrdy", i), 64'(in_ready), 64'd0);
                    chk($sformatf("stall%0d_tags", i), {out_sop, out_eop, pilot, sym_idx},
                        {1'b0, 1'b0, 1'b0, 16'd0});
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        compare_stream("stall", 1);

        // Random valid/ready toggling over 100 frames with idle junk between frames.
        start_stream();
        for (int f = 0; f < 100; f++) begin
            int junk;
            junk = int'($urandom_range(3));
            for (int j = 0; j < junk; j++) push_beat(34'({$urandom_range(3), $urandom}), 1'b0);
            for (int i = 0; i < SPF * L; i++)
                push_beat(34'({$urandom_range(3), $urandom}), i == 0);
        end
        drv_done = 0;
        fork
            begin drive(30); drv_done = 1; end
            begin
                while (!drv_done) begin
                    out_ready = (int'($urandom_range(99)) < 60);
                    @(posedge clk); #1;
                end
            end
        join
        drain();
        compare_stream("rand", 1);
        chk("rand_fd_100", 64'(fd_cnt), 64'd100);

        // SOP injected at body index 5 of symbol 0, then a full frame follows.
        start_stream();
        for (int i = 0; i < 7; i++) push_beat(34'(200 + i), i == 0);
        push_frame(300);
        drive(0);
        drain();
        compare_stream("restart", 1);
        chk("restart_err_set", 64'(sop_err), 64'd1);

        // Error flag survives a clean frame.
        start_stream();
        push_frame(400);
        drive(0);
        drain();
        compare_stream("sticky", 0);
        chk("sticky_err", 64'(sop_err), 64'd1);

        // One-cycle reset at body index 4, then a clean frame.
        start_stream();
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1; in_data = 34'(500 + k); in_sop = (k == 0);
            @(posedge clk); #1;
        end
        in_data = 34'(506); in_sop = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        chk("prst_outs", {out_valid, out_sop, out_eop, pilot, frame_done, sop_err}, 64'd0);
        chk("prst_data", 64'(out_data), 64'd0);
        chk("prst_sym", 64'(sym_idx), 64'd0);
        @(posedge clk); #1;
        start_stream();
        push_frame(600);
        drive(0);
        drain();
        compare_stream("post_rst", 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
